// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer (pipeline_ctrl).
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        MEM_WAIT  = 2'd2,
        ERR       = 2'd3
    } pipe_state_e;

    // Instruction loaded into IR_D / IR_E by the flush consumers (addi x0,x0,0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for pipeline performance counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the F, D/E, M/W pipeline with memory-timeout trap.
// Optional stall/flush performance counters are built when PIPE_PERF_CNT_EN is defined.
//
// state     | meaning
// RUN       | normal flow; Mealy stall/flush decisions from the hazard inputs
// LU_BUBBLE | one bubble sits in E; hazard and memory inputs ignored for this cycle
// MEM_WAIT  | whole pipe frozen until data memory reports ready
// ERR       | memory timeout trapped; pipe frozen until rst
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hz_stall,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ir_d_en,
    output logic             ir_d_flush,
    output logic             ir_e_en,
    output logic             ir_e_flush,
    output logic             mem_err,
    output logic [1:0]       state_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W:0] TIMEOUT_V = (WC_W + 1)'(MEM_TIMEOUT);

    pipe_state_e     state_q, state_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_err_q, mem_err_d;
    logic [WC_W:0]   wait_nxt;

    // One bit wider so the compare cannot wrap for MEM_TIMEOUT = 1.
    assign wait_nxt = {1'b0, wait_cnt_q} + 1'b1;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        pc_en      = 1'b1;
        ir_d_en    = 1'b1;
        ir_e_en    = 1'b1;
        ir_d_flush = 1'b0;
        ir_e_flush = 1'b0;

        case (state_q)
            RUN: begin
                wait_cnt_d = '0;
                if (mem_req && !mem_ready) begin
                    pc_en      = 1'b0;
                    ir_d_en    = 1'b0;
                    ir_e_en    = 1'b0;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end else if (br_taken) begin
                    ir_d_flush = 1'b1;
                    ir_e_flush = 1'b1;
                end else if (hz_stall) begin
                    pc_en      = 1'b0;
                    ir_d_en    = 1'b0;
                    ir_e_flush = 1'b1;
                    state_d    = LU_BUBBLE;
                end
            end
            LU_BUBBLE: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    pc_en   = 1'b0;
                    ir_d_en = 1'b0;
                    ir_e_en = 1'b0;
                    if (wait_nxt >= TIMEOUT_V) begin
                        state_d   = ERR;
                        mem_err_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_nxt[WC_W-1:0];
                    end
                end
            end
            ERR: begin
                pc_en   = 1'b0;
                ir_d_en = 1'b0;
                ir_e_en = 1'b0;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Reset drains the pipe regardless of the (possibly unknown) state.
        if (rst) begin
            pc_en      = 1'b0;
            ir_d_en    = 1'b0;
            ir_e_en    = 1'b0;
            ir_d_flush = 1'b1;
            ir_e_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q & ~rst;
    assign state_o = rst ? RUN : state_q;

`ifdef PIPE_PERF_CNT_EN
    logic             stall_inc;
    logic             flush_inc;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    assign stall_inc = !rst && !pc_en && (state_q != ERR);
    assign flush_inc = !rst && ir_d_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .q   (stall_q)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .q   (flush_q)
    );

    assign stall_cnt = rst ? '0 : stall_q;
    assign flush_cnt = rst ? '0 : flush_q;
`endif

endmodule
